// File: rtl/fire_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fire_sched_pkg
// Description : Shared types, source indices, actuator words and priority
//               helpers for the fire-alarm scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fire_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    // Bit positions inside every 4-bit source vector {elec,t_alta,humo,t_media}
    localparam int SRC_ELEC    = 3;
    localparam int SRC_T_ALTA  = 2;
    localparam int SRC_HUMO    = 1;
    localparam int SRC_T_MEDIA = 0;

    localparam logic [10:0] ACT_ELEC    = 11'h401;
    localparam logic [10:0] ACT_T_ALTA  = 11'h2C6;
    localparam logic [10:0] ACT_HUMO    = 11'h128;
    localparam logic [10:0] ACT_T_MEDIA = 11'h0A4;
    localparam logic [10:0] ACT_IDLE    = 11'h000;

    // One-hot of the highest-priority requester (elec first, t_media last)
    function automatic logic [3:0] prio_encode(input logic [3:0] req);
        prio_encode = 4'b0000;
        if (req[SRC_ELEC])         prio_encode[SRC_ELEC]    = 1'b1;
        else if (req[SRC_T_ALTA])  prio_encode[SRC_T_ALTA]  = 1'b1;
        else if (req[SRC_HUMO])    prio_encode[SRC_HUMO]    = 1'b1;
        else if (req[SRC_T_MEDIA]) prio_encode[SRC_T_MEDIA] = 1'b1;
    endfunction

    // Actuator word for a one-hot grant; zero when nothing is granted
    function automatic logic [10:0] action_word(input logic [3:0] sel);
        action_word = ACT_IDLE;
        if (sel[SRC_ELEC])         action_word = ACT_ELEC;
        else if (sel[SRC_T_ALTA])  action_word = ACT_T_ALTA;
        else if (sel[SRC_HUMO])    action_word = ACT_HUMO;
        else if (sel[SRC_T_MEDIA]) action_word = ACT_T_MEDIA;
    endfunction

    // Sources that outrank a one-hot grant; all-zero for no grant or for elec
    function automatic logic [3:0] higher_mask(input logic [3:0] g);
        higher_mask = ~(g | (g - 4'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchronizer for an asynchronous sensor level plus
//               a one-clock pulse on each synchronized rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge
    import fire_sched_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability chain followed by a history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/fire_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fire_alarm_scheduler
// Description : Fixed-priority arbiter that drives the 11-bit fire-machine
//               actuator word from four alarm sensors, with timed hold,
//               bounded retrigger, cooldown gap and preemption.
//               Optional: define FIRE_SCHED_STATS_EN to add the evt_cnt port
//               (four 8-bit saturating grant counters).
// Revision    : 1.0 - initial release
// ============================================================================
module fire_alarm_scheduler
    import fire_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int MAX_RETRIG  = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        t_alta,
    input  logic        t_media,
    input  logic        humo,
    input  logic        elec,
    output logic [10:0] y,
    output logic [3:0]  grant,
    output logic        busy,
    output logic [3:0]  fault
`ifdef FIRE_SCHED_STATS_EN
    ,
    output logic [31:0] evt_cnt
`endif
);

    localparam int TIMER_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);
    localparam int RETRIG_W  = (MAX_RETRIG > 0) ? $clog2(MAX_RETRIG + 1) : 1;

    localparam logic [TIMER_W-1:0]  HOLD_LOAD    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0]  GAP_LOAD     = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [RETRIG_W-1:0] RETRIG_LIMIT = RETRIG_W'(MAX_RETRIG);

    logic [3:0]          w_raw;
    logic [3:0]          w_level;
    logic [3:0]          w_rise;
    logic [3:0]          w_winner;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_pending;
    logic [3:0]          w_pending_nxt;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_nxt;
    logic [RETRIG_W-1:0] r_retrig;
    logic [RETRIG_W-1:0] w_retrig_nxt;
    logic [10:0]         w_y_nxt;
    logic [3:0]          w_grant_nxt;
    logic [3:0]          w_fault_nxt;
    logic [3:0]          w_clear;
    logic [3:0]          w_requeue;
    logic                w_busy_nxt;

    assign w_raw = {elec, t_alta, humo, t_media};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (w_raw[i]),
            .level   (w_level[i]),
            .rise    (w_rise[i])
        );
    end

    assign w_winner = prio_encode(r_pending);

    // Next-state, next-output and pending bookkeeping; holds are the default
    always_comb begin
        w_next_state = r_state;
        w_timer_nxt  = r_timer;
        w_retrig_nxt = r_retrig;
        w_y_nxt      = y;
        w_grant_nxt  = grant;
        w_fault_nxt  = fault;
        w_clear      = 4'b0000;
        w_requeue    = 4'b0000;

        case (r_state)
            IDLE: begin
                if (|r_pending) w_next_state = SELECT;
            end
            SELECT: begin
                w_next_state = ACTIVE;
                w_grant_nxt  = w_winner;
                w_clear      = w_winner;
                w_timer_nxt  = HOLD_LOAD;
                w_retrig_nxt = '0;
                w_y_nxt      = action_word(w_winner);
            end
            ACTIVE: begin
                if (|(r_pending & higher_mask(grant))) begin
                    // Preempted source goes back in the queue for later
                    w_next_state = SELECT;
                    w_requeue    = grant;
                end else if (r_timer == '0) begin
                    if (!(|(w_level & grant))) begin
                        w_next_state = COOLDOWN;
                        w_y_nxt      = ACT_IDLE;
                        w_grant_nxt  = 4'b0000;
                        w_timer_nxt  = GAP_LOAD;
                    end else if (r_retrig < RETRIG_LIMIT) begin
                        w_timer_nxt  = HOLD_LOAD;
                        w_retrig_nxt = r_retrig + RETRIG_W'(1);
                    end else begin
                        w_fault_nxt  = fault | grant;
                        w_next_state = COOLDOWN;
                        w_y_nxt      = ACT_IDLE;
                        w_grant_nxt  = 4'b0000;
                        w_timer_nxt  = GAP_LOAD;
                    end
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            COOLDOWN: begin
                if (r_timer == '0) begin
                    w_next_state = (|r_pending) ? SELECT : IDLE;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // A fresh edge wins over a same-cycle clear of the same bit
        w_pending_nxt = (r_pending & ~w_clear) | w_rise | w_requeue;
    end

    assign w_busy_nxt = (w_next_state != IDLE);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_pending <= 4'b0000;
            r_timer   <= '0;
            r_retrig  <= '0;
            y         <= ACT_IDLE;
            grant     <= 4'b0000;
            busy      <= 1'b0;
            fault     <= 4'b0000;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_nxt;
            r_timer   <= w_timer_nxt;
            r_retrig  <= w_retrig_nxt;
            y         <= w_y_nxt;
            grant     <= w_grant_nxt;
            busy      <= w_busy_nxt;
            fault     <= w_fault_nxt;
        end
    end

`ifdef FIRE_SCHED_STATS_EN
    for (genvar i = 0; i < 4; i++) begin : g_stats
        logic [7:0] r_cnt;

        // Saturating count of grants issued to this source
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= 8'h00;
            end else if ((r_state == SELECT) && w_winner[i] && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign evt_cnt[i*8 +: 8] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fire_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fire_alarm_scheduler
// Description : Self-checking bench for fire_alarm_scheduler with a
//               cycle-level behavioural model and directed scenarios.
//               Honours FIRE_SCHED_STATS_EN for the evt_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fire_alarm_scheduler;

    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int MAXR = 1;

    localparam int M_IDLE = 0;
    localparam int M_SEL  = 1;
    localparam int M_ACT  = 2;
    localparam int M_COOL = 3;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        t_alta  = 1'b0;
    logic        t_media = 1'b0;
    logic        humo    = 1'b0;
    logic        elec    = 1'b0;
    logic [10:0] y;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  fault;
`ifdef FIRE_SCHED_STATS_EN
    logic [31:0] evt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fire_alarm_scheduler #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .MAX_RETRIG  (MAXR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .t_alta  (t_alta),
        .t_media (t_media),
        .humo    (humo),
        .elec    (elec),
        .y       (y),
        .grant   (grant),
        .busy    (busy),
        .fault   (fault)
`ifdef FIRE_SCHED_STATS_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Source index 0..3 = t_media, humo, t_alta, elec; larger index = higher priority.
    logic [10:0] WORDS [4] = '{11'h0A4, 11'h128, 11'h2C6, 11'h401};

    int          m_mode;
    int          m_src;
    int          m_left;
    int          m_slots;
    logic [3:0]  m_pend;
    logic [3:0]  m_s1, m_s2, m_s3;
    logic [10:0] m_y;
    logic [3:0]  m_fault;
    int          m_cnt [4];
    logic [3:0]  t_rise, t_lvl, t_clr, t_rq;
    bit          t_pre;
    int          t_top;

    function automatic logic [3:0] m_grant();
        return (m_src >= 0) ? (4'b0001 << m_src) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_src = -1; m_left = 0; m_slots = 0;
        m_pend = 4'b0; m_s1 = 4'b0; m_s2 = 4'b0; m_s3 = 4'b0;
        m_y = 11'h0; m_fault = 4'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic go_cool();
        m_mode = M_COOL; m_left = GAP; m_y = 11'h0; m_src = -1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
            end else begin
                t_rise = m_s2 & ~m_s3;
                t_lvl  = m_s2;
                m_s3 = m_s2; m_s2 = m_s1; m_s1 = {elec, t_alta, humo, t_media};
                t_clr = 4'b0; t_rq = 4'b0;
                case (m_mode)
                    M_IDLE: if (m_pend != 4'b0) m_mode = M_SEL;
                    M_SEL: begin
                        t_top = -1;
                        for (int i = 0; i < 4; i++) if (m_pend[i]) t_top = i;
                        m_mode = M_ACT; m_left = HOLD; m_slots = 0;
                        m_src = t_top;
                        if (t_top >= 0) begin
                            t_clr[t_top] = 1'b1;
                            m_y = WORDS[t_top];
                            if (m_cnt[t_top] < 255) m_cnt[t_top]++;
                        end else begin
                            m_y = 11'h0;
                        end
                    end
                    M_ACT: begin
                        t_pre = 1'b0;
                        for (int j = 0; j < 4; j++) if (j > m_src && m_pend[j]) t_pre = 1'b1;
                        if (t_pre) begin
                            m_mode = M_SEL;
                            if (m_src >= 0) t_rq[m_src] = 1'b1;
                        end else if (m_left == 1) begin
                            if (m_src < 0 || !t_lvl[m_src]) go_cool();
                            else if (m_slots < MAXR) begin m_left = HOLD; m_slots++; end
                            else begin m_fault[m_src] = 1'b1; go_cool(); end
                        end else begin
                            m_left--;
                        end
                    end
                    default: begin
                        if (m_left == 1) m_mode = (m_pend != 4'b0) ? M_SEL : M_IDLE;
                        else m_left--;
                    end
                endcase
                m_pend = (m_pend & ~t_clr) | t_rise | t_rq;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("y",     32'(y),     32'(m_y));
            check("grant", 32'(grant), 32'(m_grant()));
            check("busy",  32'(busy),  32'(m_mode != M_IDLE));
            check("fault", 32'(fault), 32'(m_fault));
`ifdef FIRE_SCHED_STATS_EN
            check("evt_cnt", evt_cnt, {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [3:0] m);
        {elec, t_alta, humo, t_media} = m;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        adv(3);
        check("rst_y",     32'(y),     32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        adv(2);

        // humo one-clock pulse: edge numbers counted from the sampling edge E1
        @(negedge clk) drive(4'b0010);
        adv(1);
        @(negedge clk) drive(4'b0000);
        adv(3);
        check("humo_sel_y",    32'(y),    32'h0);
        check("humo_sel_busy", 32'(busy), 32'h1);
        adv(1);
        check("humo_e5_y",     32'(y),     32'h128);
        check("humo_e5_grant", 32'(grant), 32'h2);
        adv(3);
        check("humo_e8_y",     32'(y),     32'h128);
        adv(1);
        check("humo_e9_y",     32'(y),     32'h0);
        check("humo_e9_busy",  32'(busy),  32'h1);
        adv(1);
        check("humo_e10_busy", 32'(busy),  32'h1);
        adv(1);
        check("humo_e11_busy", 32'(busy),  32'h0);
        check("humo_fault",    32'(fault), 32'h0);
        adv(2);

        // elec and t_media together: elec first, t_media after the gap
        @(negedge clk) drive(4'b1001);
        adv(1);
        @(negedge clk) drive(4'b0000);
        adv(4);
        check("dual_e5_y",      32'(y),     32'h401);
        check("dual_e5_grant",  32'(grant), 32'h8);
        adv(7);
        check("dual_e12_y",     32'(y),     32'h0A4);
        check("dual_e12_grant", 32'(grant), 32'h1);
        adv(8);
        check("dual_idle_busy", 32'(busy),  32'h0);

        // humo served, elec arrives mid-slot and preempts
        @(negedge clk) drive(4'b0010);
        adv(1);
        @(negedge clk) drive(4'b0000);
        adv(3);
        @(negedge clk) drive(4'b1000);
        adv(1);
        check("pre_e5_y", 32'(y), 32'h128);
        @(negedge clk) drive(4'b0000);
        adv(3);
        check("pre_sel_y",     32'(y),     32'h128);
        check("pre_sel_busy",  32'(busy),  32'h1);
        adv(1);
        check("pre_elec_y",    32'(y),     32'h401);
        check("pre_elec_gnt",  32'(grant), 32'h8);
        adv(7);
        check("pre_humo_y",    32'(y),     32'h128);
        check("pre_humo_gnt",  32'(grant), 32'h2);
        adv(8);
        check("pre_idle_busy", 32'(busy),  32'h0);

        // t_alta held: two hold slots then fault and cooldown
        @(negedge clk) drive(4'b0100);
        adv(5);
        check("ta_e5_y",     32'(y),     32'h2C6);
        check("ta_e5_grant", 32'(grant), 32'h4);
        adv(3);
        check("ta_e8_y",     32'(y),     32'h2C6);
        adv(4);
        check("ta_e12_y",    32'(y),     32'h2C6);
        check("ta_e12_flt",  32'(fault), 32'h0);
        adv(1);
        check("ta_e13_y",    32'(y),     32'h0);
        check("ta_e13_gnt",  32'(grant), 32'h0);
        check("ta_e13_flt",  32'(fault), 32'h4);
        @(negedge clk) drive(4'b0000);
        adv(4);
        check("ta_idle_busy", 32'(busy), 32'h0);
        check("ta_sticky",    32'(fault), 32'h4);

        // reset during ACTIVE with humo held through release
        @(negedge clk) drive(4'b0010);
        adv(6);
        check("rm_e6_y", 32'(y), 32'h128);
        #2 reset_n = 1'b0;
        #1;
        check("rm_y",     32'(y),     32'h0);
        check("rm_grant", 32'(grant), 32'h0);
        check("rm_busy",  32'(busy),  32'h0);
        check("rm_fault", 32'(fault), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        adv(4);
        check("rm_e4_y",  32'(y),     32'h0);
        adv(1);
        check("rm_e5_y",  32'(y),     32'h128);
        check("rm_e5_gnt", 32'(grant), 32'h2);
        @(negedge clk) drive(4'b0000);
        adv(8);
        check("rm_idle_busy", 32'(busy), 32'h0);

`ifdef FIRE_SCHED_STATS_EN
        // humo pulses spaced past a full service: humo counter saturates
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("stats_reset", evt_cnt, 32'h0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk) drive(4'b0010);
            adv(1);
            @(negedge clk) drive(4'b0000);
            adv(14);
        end
        check("stats_sat", evt_cnt, 32'h0000_FF00);
`endif

        adv(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
